// File: rtl/wm8978_i2c_wr.sv
// I2C master write engine for the WM8978 codec control port.
// One i2c_exec pulse sends {dev_addr+W, {reg_addr, d8}, d[7:0]} as a
// three-byte write, then reports completion on i2c_done and any NACK on
// i2c_ack. SCL is push-pull; SDA is open-drain (drives 0 or releases).
module wm8978_i2c_wr #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h1A,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned I2C_FREQ   = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_exec,
  input  logic [15:0] i2c_data,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        scl,
  inout  wire         sda,
  output logic [3:0]  state_dbg
);

  // Handshake: i2c_exec is a 1-clk request honoured only while the FSM is
  // IDLE (i2c_data is captured on that same edge, otherwise the pulse is
  // dropped); i2c_done is a 1-clk completion pulse issued after STOP, and
  // the FSM is already IDLE in that cycle, so a request in the next clk is
  // accepted. i2c_ack holds the NACK status from done until the next accept.

  // Clocks per SCL quarter period; the configuration must give DIV >= 2.
  localparam int unsigned DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned DW  = $clog2(DIV);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    BYTE0 = 4'd2,
    ACK0  = 4'd3,
    BYTE1 = 4'd4,
    ACK1  = 4'd5,
    BYTE2 = 4'd6,
    ACK2  = 4'd7,
    STOP  = 4'd8
  } state_t;

  state_t          state, state_n;
  logic [1:0]      q, q_n;            // quarter within the current bit slot
  logic [2:0]      bit_idx, bit_n;    // bit within the current byte, 0 = MSB
  logic [15:0]     data_r, data_n;
  logic            ack_r, ack_n;
  logic            nack_r, nack_n;    // SDA level sampled in the ACK slot
  logic            done_r, done_n;
  logic            scl_r, scl_n;
  logic            low_r, low_n;      // 1 = pull SDA low
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic            sda_in;
  logic [7:0]      cur_byte;

  assign sda_in    = sda;
  assign tick      = (div_cnt == DW'(DIV - 1));
  assign scl       = scl_r;
  assign sda       = low_r ? 1'b0 : 1'bz;
  assign i2c_done  = done_r;
  assign i2c_ack   = ack_r;
  assign state_dbg = state;

  // Quarter-period timebase; held at zero while idle so each transfer starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (state == IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // State and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      q       <= 2'd0;
      bit_idx <= 3'd0;
      data_r  <= 16'd0;
      ack_r   <= 1'b0;
      nack_r  <= 1'b0;
      done_r  <= 1'b0;
      scl_r   <= 1'b1;
      low_r   <= 1'b0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      bit_idx <= bit_n;
      data_r  <= data_n;
      ack_r   <= ack_n;
      nack_r  <= nack_n;
      done_r  <= done_n;
      scl_r   <= scl_n;
      low_r   <= low_n;
    end
  end

  // Next-state: accept in IDLE, otherwise step one quarter per tick.
  always_comb begin
    state_n = state;
    q_n     = q;
    bit_n   = bit_idx;
    data_n  = data_r;
    ack_n   = ack_r;
    nack_n  = nack_r;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (i2c_exec) begin
        state_n = START;
        q_n     = 2'd0;
        bit_n   = 3'd0;
        data_n  = i2c_data;
        ack_n   = 1'b0;
        nack_n  = 1'b0;
      end
    end else if (tick) begin
      q_n = q + 2'd1;
      // Slave answer is read at the end of q2, mid SCL-high.
      if ((state == ACK0 || state == ACK1 || state == ACK2) && q == 2'd2) begin
        nack_n = sda_in;
        if (sda_in) ack_n = 1'b1;
      end
      if (q == 2'd3) begin
        case (state)
          START: begin
            state_n = BYTE0;
            bit_n   = 3'd0;
          end
          BYTE0, BYTE1, BYTE2: begin
            if (bit_idx == 3'd7) begin
              bit_n = 3'd0;
              case (state)
                BYTE0:   state_n = ACK0;
                BYTE1:   state_n = ACK1;
                default: state_n = ACK2;
              endcase
            end else begin
              bit_n = bit_idx + 3'd1;
            end
          end
          ACK0:    state_n = nack_r ? STOP : BYTE1;
          ACK1:    state_n = nack_r ? STOP : BYTE2;
          ACK2:    state_n = STOP;
          STOP: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Bus levels for the position being entered, so they register cleanly.
  always_comb begin
    scl_n    = 1'b1;
    low_n    = 1'b0;
    cur_byte = data_r[7:0];
    case (state_n)
      BYTE0:   cur_byte = {SLAVE_ADDR, 1'b0};
      BYTE1:   cur_byte = data_r[15:8];
      default: cur_byte = data_r[7:0];
    endcase
    case (state_n)
      START: begin
        scl_n = (q_n != 2'd3);
        low_n = q_n[1];
      end
      BYTE0, BYTE1, BYTE2: begin
        scl_n = q_n[1];
        low_n = ~cur_byte[3'd7 - bit_n];
      end
      ACK0, ACK1, ACK2: begin
        scl_n = q_n[1];
        low_n = 1'b0;
      end
      STOP: begin
        scl_n = (q_n != 2'd0);
        low_n = ~q_n[1];
      end
      default: begin
        scl_n = 1'b1;
        low_n = 1'b0;
      end
    endcase
  end

endmodule
